// File: rtl/idct_block_mover.sv
`default_nettype none
// ============================================================================
// idct_block_mover - BLK x BLK block mover between SRAM and the IDCT buffer:
// fetch sign-extends SRAM words, store scales/clips/packs pixel pairs.
// Rev 1.0
// ============================================================================
module idct_block_mover #(
  parameter int BLK       = 8,
  parameter int SRAM_AW   = 18,
  parameter int SRAM_DW   = 16,
  parameter int BUF_AW    = 7,
  parameter int BUF_DW    = 32,
  parameter int FETCH_LAT = 2,
  parameter int SHIFT     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [SRAM_AW-1:0] base_address,
  input  logic [SRAM_AW-1:0] row_stride,
  input  logic [BUF_AW-1:0]  buf_base,
  output logic               busy,
  output logic               done,
  output logic [SRAM_AW-1:0] sram_address,
  input  logic [SRAM_DW-1:0] sram_read_data,
  output logic [SRAM_DW-1:0] sram_write_data,
  output logic               sram_we_n,
  output logic [BUF_AW-1:0]  buf_address,
  output logic [BUF_DW-1:0]  buf_write_data,
  output logic               buf_we,
  input  logic [BUF_DW-1:0]  buf_read_data
);

  localparam int LOG = $clog2(BLK);
  localparam int IW  = 2 * LOG;
  localparam int CW  = IW + 1;
  localparam int N   = BLK * BLK;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_F_RUN   = 3'd1;
  localparam logic [2:0] ST_F_DRAIN = 3'd2;
  localparam logic [2:0] ST_S_RUN   = 3'd3;
  localparam logic [2:0] ST_S_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic               mode_q, mode_d;
  logic [SRAM_AW-1:0] stride_q, stride_d;
  logic [SRAM_AW-1:0] row_q, row_d;
  logic [SRAM_AW-1:0] sram_address_q, sram_address_d;
  logic [SRAM_DW-1:0] sram_write_data_q, sram_write_data_d;
  logic               sram_we_n_q, sram_we_n_d;
  logic [BUF_AW-1:0]  buf_address_q, buf_address_d;
  logic [BUF_AW-1:0]  buf_ptr_q, buf_ptr_d;
  logic [BUF_DW-1:0]  buf_write_data_q, buf_write_data_d;
  logic               buf_we_q, buf_we_d;
  logic [IW-1:0]      iss_q, iss_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [FETCH_LAT-1:0] pipe_q, pipe_d;
  logic [7:0]         pix_even_q, pix_even_d;

  logic               accept;
  logic               issue_v;
  logic               iss_last;
  logic               xfer_end;
  logic signed [BUF_DW-1:0] scaled;
  logic [7:0]         pix;

  assign accept   = (state_q == ST_IDLE) && start;
  assign issue_v  = (state_q == ST_F_RUN) || (state_q == ST_S_RUN);
  assign iss_last = (iss_q == IW'(N - 1));
  // cnt_q counts elements retired on the data side (buffer writes or pixels)
  assign xfer_end = (cnt_q == CW'(N));

  assign scaled = $signed(buf_read_data) >>> SHIFT;
  assign pix    = scaled[BUF_DW-1]      ? 8'h00 :
                  (|scaled[BUF_DW-2:8]) ? 8'hFF : scaled[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = mode ? ST_S_RUN : ST_F_RUN;
      ST_F_RUN:   if (iss_last) state_d = ST_F_DRAIN;
      ST_F_DRAIN: if (xfer_end) state_d = ST_DONE;
      ST_S_RUN:   if (iss_last) state_d = ST_S_DRAIN;
      ST_S_DRAIN: if (xfer_end) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    mode_d            = mode_q;
    stride_d          = stride_q;
    row_d             = row_q;
    sram_address_d    = sram_address_q;
    sram_write_data_d = sram_write_data_q;
    sram_we_n_d       = 1'b1;
    buf_address_d     = buf_address_q;
    buf_ptr_d         = buf_ptr_q;
    buf_write_data_d  = buf_write_data_q;
    buf_we_d          = 1'b0;
    iss_d             = iss_q;
    cnt_d             = cnt_q;
    pix_even_d        = pix_even_q;

    pipe_d[0] = issue_v;
    for (int i = 1; i < FETCH_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (accept) begin
      mode_d         = mode;
      stride_d       = row_stride;
      row_d          = base_address;
      sram_address_d = base_address;
      buf_address_d  = buf_base;
      buf_ptr_d      = buf_base;
      iss_d          = '0;
      cnt_d          = '0;
    end

    if (issue_v && !iss_last) begin
      iss_d = iss_q + IW'(1);
    end

    // Fetch issue side: row base advances by stride, no multiplier needed
    if ((state_q == ST_F_RUN) && !iss_last) begin
      if (iss_q[LOG-1:0] == LOG'(BLK - 1)) begin
        row_d          = row_q + stride_q;
        sram_address_d = row_q + stride_q;
      end else begin
        sram_address_d = sram_address_q + SRAM_AW'(1);
      end
    end

    if ((state_q == ST_S_RUN) && !iss_last) begin
      buf_address_d = buf_address_q + BUF_AW'(1);
    end

    if (!mode_q && pipe_q[FETCH_LAT-1]) begin
      buf_we_d         = 1'b1;
      buf_write_data_d = {{(BUF_DW-SRAM_DW){sram_read_data[SRAM_DW-1]}}, sram_read_data};
      buf_address_d    = buf_ptr_q;
      buf_ptr_d        = buf_ptr_q + BUF_AW'(1);
      cnt_d            = cnt_q + CW'(1);
    end

    // Store data side: even pixel waits, odd pixel completes the pair write
    if (mode_q && pipe_q[0]) begin
      cnt_d = cnt_q + CW'(1);
      if (!cnt_q[0]) begin
        pix_even_d = pix;
      end else begin
        sram_we_n_d       = 1'b0;
        sram_write_data_d = {pix_even_q, pix};
        sram_address_d    = row_q + SRAM_AW'(cnt_q[LOG-1:0] >> 1);
        if (cnt_q[LOG-1:0] == LOG'(BLK - 1)) begin
          row_d = row_q + stride_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q            <= 1'b0;
      stride_q          <= '0;
      row_q             <= '0;
      sram_address_q    <= '0;
      sram_write_data_q <= '0;
      sram_we_n_q       <= 1'b1;
      buf_address_q     <= '0;
      buf_ptr_q         <= '0;
      buf_write_data_q  <= '0;
      buf_we_q          <= 1'b0;
      iss_q             <= '0;
      cnt_q             <= '0;
      pipe_q            <= '0;
      pix_even_q        <= '0;
    end else begin
      mode_q            <= mode_d;
      stride_q          <= stride_d;
      row_q             <= row_d;
      sram_address_q    <= sram_address_d;
      sram_write_data_q <= sram_write_data_d;
      sram_we_n_q       <= sram_we_n_d;
      buf_address_q     <= buf_address_d;
      buf_ptr_q         <= buf_ptr_d;
      buf_write_data_q  <= buf_write_data_d;
      buf_we_q          <= buf_we_d;
      iss_q             <= iss_d;
      cnt_q             <= cnt_d;
      pipe_q            <= pipe_d;
      pix_even_q        <= pix_even_d;
    end
  end

  assign sram_address    = sram_address_q;
  assign sram_write_data = sram_write_data_q;
  assign sram_we_n       = sram_we_n_q;
  assign buf_address     = buf_address_q;
  assign buf_write_data  = buf_write_data_q;
  assign buf_we          = buf_we_q;

endmodule
`default_nettype wire

// File: tb/tb_idct_block_mover.sv
`default_nettype none
// ============================================================================
// tb_idct_block_mover - directed bench with SRAM and block-buffer models.
// Rev 1.0
// ============================================================================
module tb_idct_block_mover;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [17:0] base_address, row_stride;
  logic [6:0]  buf_base;
  logic        busy, done, sram_we_n, buf_we;
  logic [17:0] sram_address;
  logic [15:0] sram_read_data, sram_write_data;
  logic [6:0]  buf_address;
  logic [31:0] buf_write_data, buf_read_data;

  always #5 clk = ~clk;

  idct_block_mover #(
    .BLK(8), .SRAM_AW(18), .SRAM_DW(16), .BUF_AW(7), .BUF_DW(32),
    .FETCH_LAT(2), .SHIFT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .base_address(base_address), .row_stride(row_stride), .buf_base(buf_base),
    .busy(busy), .done(done),
    .sram_address(sram_address), .sram_read_data(sram_read_data),
    .sram_write_data(sram_write_data), .sram_we_n(sram_we_n),
    .buf_address(buf_address), .buf_write_data(buf_write_data),
    .buf_we(buf_we), .buf_read_data(buf_read_data)
  );

  // SRAM: data FETCH_LAT=2 cycles after address
  logic [17:0] a_d1, a_d2;
  logic        sram_const;
  always @(posedge clk) begin
    a_d1 <= sram_address;
    a_d2 <= a_d1;
  end
  assign sram_read_data = sram_const ? 16'h8001 : a_d2[15:0];

  logic [31:0] mem [128];
  logic        ld_we;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (buf_we) mem[buf_address] <= buf_write_data;
    buf_read_data <= mem[buf_address];
  end

  // Event monitor; rel = cycle number relative to the Start sampling edge
  logic        mon_clr;
  int          rel, bw_cnt, bw_first, bw_last, sw_cnt, sw_first, sw_last;
  int          done_cnt, done_cyc, busy_cnt, busy_first, busy_last;
  logic [17:0] sw_addr [32];
  logic [15:0] sw_data [32];
  always @(negedge clk) begin
    if (mon_clr) begin
      rel = 0; bw_cnt = 0; bw_first = -1; bw_last = -1;
      sw_cnt = 0; sw_first = -1; sw_last = -1;
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    end else begin
      rel = rel + 1;
      if (buf_we) begin
        if (bw_cnt == 0) bw_first = rel;
        bw_last = rel;
        bw_cnt++;
      end
      if (!sram_we_n) begin
        if (sw_cnt < 32) begin
          sw_addr[sw_cnt] = sram_address;
          sw_data[sw_cnt] = sram_write_data;
        end
        if (sw_cnt == 0) sw_first = rel;
        sw_last = rel;
        sw_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = rel;
      end
      if (busy) begin
        if (busy_cnt == 0) busy_first = rel;
        busy_last = rel;
        busy_cnt++;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic go(input logic m, input logic [17:0] b, input logic [17:0] s,
                    input logic [6:0] bb);
    mode = m; base_address = b; row_stride = s; buf_base = bb;
    start = 1'b1; mon_clr = 1'b1; cur = 0;
    tick();
    start = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cur < n) tick();
  endtask

  task automatic preload_store();
    logic [31:0] pat [4];
    pat[0] = 32'hFFFF0000; pat[1] = 32'h7FFF0000;
    pat[2] = 32'h00800000; pat[3] = 32'h00050000;
    for (int k = 0; k < 64; k++) begin
      ld_we = 1'b1; ld_addr = 7'(k); ld_data = pat[k % 4];
      tick();
    end
    ld_we = 1'b0;
  endtask

  initial begin
    logic [15:0] a16;
    logic [17:0] a18;
    rst = 1'b1; start = 1'b0; mode = 1'b0; base_address = '0; row_stride = '0;
    buf_base = '0; sram_const = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    mon_clr = 1'b1;
    repeat (3) tick();
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_we", 64'({sram_we_n, buf_we}), 64'b10);
    chk("rst_sram", 64'({sram_address, sram_write_data}), 64'd0);
    chk("rst_buf", 64'({buf_address, buf_write_data}), 64'd0);
    rst = 1'b0;
    tick();

    // 1: fetch with defaults
    go(1'b0, 18'd76800, 18'd320, 7'd0);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    run_to(75);
    chk("t1_bw_cnt", 64'(bw_cnt), 64'd64);
    chk("t1_bw_first", 64'(bw_first), 64'd4);
    chk("t1_bw_last", 64'(bw_last), 64'd67);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_done_cyc", 64'(done_cyc), 64'd68);
    chk("t1_sw_cnt", 64'(sw_cnt), 64'd0);
    chk("t1_buf0", 64'(mem[0]), 64'h00002C00);
    chk("t1_buf63", 64'(mem[63]), 64'h000034C7);
    for (int k = 0; k < 64; k++) begin
      a16 = 16'(76800 + 320 * (k / 8) + (k % 8));
      chk($sformatf("t1_buf[%0d]", k), 64'(mem[k]), 64'({{16{a16[15]}}, a16}));
    end

    // 2: sign extension
    sram_const = 1'b1;
    go(1'b0, 18'd0, 18'd8, 7'd64);
    run_to(75);
    sram_const = 1'b0;
    chk("t2_done_cyc", 64'(done_cyc), 64'd68);
    for (int k = 64; k < 128; k++) begin
      chk($sformatf("t2_buf[%0d]", k), 64'(mem[k]), 64'hFFFF8001);
    end

    // 3: store with clipping; pixels per group of 4 are 0,255,128,5
    preload_store();
    go(1'b1, 18'd0, 18'd160, 7'd0);
    run_to(75);
    chk("t3_sw_cnt", 64'(sw_cnt), 64'd32);
    chk("t3_sw_first", 64'(sw_first), 64'd4);
    chk("t3_sw_last", 64'(sw_last), 64'd66);
    chk("t3_bw_cnt", 64'(bw_cnt), 64'd0);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);
    chk("t3_done_cyc", 64'(done_cyc), 64'd67);
    chk("t3_first_pair", 64'(sw_data[0]), 64'h00FF);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("t3_addr[%0d]", j), 64'(sw_addr[j]), 64'(160 * (j / 4) + (j % 4)));
      chk($sformatf("t3_data[%0d]", j), 64'(sw_data[j]), (j % 2 == 1) ? 64'h8005 : 64'h00FF);
    end

    // 4: handshake - Start pulses during the fetch and in the Done cycle
    go(1'b0, 18'd0, 18'd8, 7'd0);
    run_to(10);
    start = 1'b1; mode = 1'b1; base_address = 18'h3FFFF; buf_base = 7'd99;
    tick();
    start = 1'b0;
    run_to(67);
    start = 1'b1;
    tick();
    chk("t4_c68_busy_done", 64'({busy, done}), 64'b11);
    tick();
    start = 1'b0;
    chk("t4_c69_busy_done", 64'({busy, done}), 64'b00);
    chk("t4_busy_cnt", 64'(busy_cnt), 64'd68);
    chk("t4_busy_span", 64'({busy_first[15:0], busy_last[15:0]}), 64'({16'd1, 16'd68}));
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);
    chk("t4_sw_cnt", 64'(sw_cnt), 64'd0);
    chk("t4_bw_cnt", 64'(bw_cnt), 64'd64);
    chk("t4_buf63", 64'(mem[63]), 64'd63);
    go(1'b0, 18'd200, 18'd8, 7'd64);
    chk("t4_restart_busy", 64'(busy), 64'd1);
    run_to(75);
    chk("t4_restart_done", 64'(done_cyc), 64'd68);
    chk("t4_restart_buf64", 64'(mem[64]), 64'd200);

    // 5: reset in cycle 30 of a store
    preload_store();
    go(1'b1, 18'd0, 18'd160, 7'd0);
    run_to(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy_done", 64'({busy, done}), 64'b00);
    chk("t5_we", 64'({sram_we_n, buf_we}), 64'b10);
    run_to(80);
    chk("t5_sw_cnt", 64'(sw_cnt), 64'd14);
    chk("t5_done_cnt", 64'(done_cnt), 64'd0);
    chk("t5_busy_last", 64'(busy_last), 64'd30);
    go(1'b0, 18'd100, 18'd16, 7'd0);
    run_to(75);
    chk("t5_fetch_bw", 64'(bw_cnt), 64'd64);
    chk("t5_fetch_done", 64'(done_cyc), 64'd68);
    chk("t5_fetch_buf9", 64'(mem[9]), 64'd117);

    // 6: SRAM and buffer address wrap
    go(1'b0, 18'd262140, 18'd16, 7'd120);
    run_to(75);
    chk("t6_bw_cnt", 64'(bw_cnt), 64'd64);
    chk("t6_done_cyc", 64'(done_cyc), 64'd68);
    chk("t6_buf120", 64'(mem[120]), 64'hFFFFFFFC);
    chk("t6_buf123", 64'(mem[123]), 64'hFFFFFFFF);
    chk("t6_buf124", 64'(mem[124]), 64'h0);
    chk("t6_buf127", 64'(mem[127]), 64'h3);
    chk("t6_buf0", 64'(mem[0]), 64'hC);
    chk("t6_buf55", 64'(mem[55]), 64'h73);
    chk("t6_buf56_untouched", 64'(mem[56]), 64'hD4);
    for (int k = 0; k < 64; k++) begin
      a18 = 18'(262140 + 16 * (k / 8) + (k % 8));
      chk($sformatf("t6_buf[%0d]", (120 + k) % 128), 64'(mem[(120 + k) % 128]),
          64'({{16{a18[15]}}, a18[15:0]}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
